eb_issue_scheduler: RTL and testbench
=====================================

Name: eb_issue_scheduler

Overview:
- Out-of-order issue controller for the execution buffer.
- Accepts decoded ops from dispatch into L entries and tracks source readiness from writeback tag broadcasts.
- Selects the oldest ready entry each cycle and hands it to the ALU through a registered valid/ready issue stage.
- Sits between rename/dispatch and the ALU; the ROB drives flush.

Parameters:
- L, 8: number of scheduler entries; power of two, >= 2.
- TAG_W, $clog2(`NUM_D_REG): physical data-register tag width.
- ROB_W, 4: ROB index width.

Ports:
- clk  input  1  clock
- n_rst  input  1  asynchronous active-low reset
- disp_valid  input  1  dispatch op offered
- disp_ready  output  1  scheduler can accept
- disp_op  input  $bits(eb_payload_t)  payload: alu_op, immdt[5:0], use_ra/ra_tag, use_rt/rt_tag, use_rw/rw_tag, rv_addr[15:0], rs_addr, rob_tag
- disp_ra_rdy  input  1  ra already available at dispatch
- disp_rt_rdy  input  1  rt already available at dispatch
- wb_valid  input  1  writeback tag broadcast
- wb_tag  input  TAG_W  tag being written
- iss_valid  output  1  issue register holds an op
- iss_ready  input  1  ALU accepts
- iss_op  output  $bits(eb_payload_t)  issued payload
- flush  input  1  discard all contents (synchronous)
- count  output  $clog2(L)+1  occupied entries (issue register excluded)

Behaviour:
- Reset (n_rst low, asynchronous):
  - all entry valid bits, ra/rt ready bits and the age matrix clear;
  - iss_valid=0, iss_op=0, count=0, disp_ready=1.
- Dispatch:
  - disp_ready = (count != L); no same-cycle reuse of a freed slot.
  - On disp_valid && disp_ready, the lowest-index free entry is written.
  - Stored ra_ready = ~use_ra | disp_ra_rdy | (wb_valid && wb_tag==ra_tag); rt_ready is computed the same way. This same-cycle bypass is mandatory.
- Wakeup: on wb_valid, every valid entry whose used source tag equals wb_tag sets that ready bit on the next edge. One broadcast per cycle.
- Readiness: entry ready = valid & (~use_ra | ra_ready) & (~use_rt | rt_ready), computed from registered state only.
- Age:
  - LxL matrix; older[i][j]=1 means entry i was allocated before entry j.
  - On allocating entry k: older[j][k]=1 for every valid j not leaving this cycle; older[k][*]=0.
  - Select = the ready entry with no ready, older, valid peer. Exactly one entry or none.
- Issue register:
  - Loads when a selection exists and (~iss_valid | iss_ready). The selected entry is freed on that edge.
  - iss_valid/iss_op hold stable while iss_valid && ~iss_ready.
  - On iss_valid && iss_ready with no selection, iss_valid drops to 0.
- Latency:
  - Dispatch at edge N with sources ready gives iss_valid at cycle N+1 at the earliest (select in cycle N, after the entry is written, then load at edge N+1). Minimum 2 edges from dispatch handshake to iss_valid.
  - Wakeup at edge N gives issue-register load at edge N+1 at the earliest.
- count:
  - +1 on dispatch, -1 on load into the issue register; both in the same cycle leaves it unchanged.
  - Never exceeds L.
- Flush:
  - Clears all entries, the age matrix and iss_valid on the next edge. A dispatch in the flush cycle is dropped.
  - disp_ready is unaffected combinationally.
- Simultaneous events:
  - Dispatch into slot k while a different slot frees: both take effect.
  - Wakeup and selection in the same cycle: selection uses pre-wakeup state.
- Selection ties cannot occur because the age matrix is a strict order.

Decomposition:
- nand_cpu_pkg gains:
  - eb_payload_t packed struct (fields listed under disp_op);
  - EB_ENTRIES localparam default;
  - AluOp, which already exists there.
- One sub-module: eb_age_select (LxL age matrix update plus oldest-ready one-hot select; inputs ready vector, alloc one-hot, free one-hot).

Test Plan:
- Reset mid-operation: 3 entries valid, iss_valid=1, pull n_rst low between edges -> iss_valid=0 and count=0 immediately; disp_ready=1.
- Ordering: dispatch A, B, C (all ready, back-to-back), iss_ready=1 -> iss_op rob_tag sequence 0,1,2. First iss_valid 2 edges after A's handshake.
- Wakeup and age: dispatch X (ra_tag=5, not ready), then Y (ready). Broadcast wb_tag=5 while Y sits in the stalled issue register -> after release, X issues next despite arriving later-ready, as the oldest ready entry.
- Same-cycle bypass: dispatch with rt_tag=3 not ready while wb_valid, wb_tag=3 -> entry issues without any later broadcast.
- Full/backpressure: iss_ready=0, dispatch L+1 ops -> count=L, disp_ready=0, the (L+1)th op is not accepted, iss_op stable. Raise iss_ready -> count decrements and disp_ready returns to 1 the next cycle.
- Flush: 5 entries, iss_valid=1, plus a dispatch in the flush cycle -> next cycle count=0, iss_valid=0, and the flushed-cycle dispatch never issues.

Source files
------------

// File: rtl/nand_cpu_pkg.sv
// Shared CPU types: ALU opcodes, register/ROB widths and the execution-buffer payload.
package nand_cpu_pkg;

    localparam int unsigned NUM_D_REG  = 16;
    localparam int unsigned EB_TAG_W   = $clog2(NUM_D_REG);
    localparam int unsigned EB_ROB_W   = 4;
    localparam int unsigned EB_ENTRIES = 8;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NAND = 4'd5,
        ALU_SHL  = 4'd6,
        ALU_SHR  = 4'd7
    } AluOp;

    typedef struct packed {
        AluOp                alu_op;
        logic [5:0]          immdt;
        logic                use_ra;
        logic [EB_TAG_W-1:0] ra_tag;
        logic                use_rt;
        logic [EB_TAG_W-1:0] rt_tag;
        logic                use_rw;
        logic [EB_TAG_W-1:0] rw_tag;
        logic [15:0]         rv_addr;
        logic [15:0]         rs_addr;
        logic [EB_ROB_W-1:0] rob_tag;
    } eb_payload_t;

endpackage

// File: rtl/eb_issue_scheduler_age_select.sv
// Age matrix for the scheduler entries plus oldest-ready one-hot selection.
module eb_age_select #(
    parameter int unsigned L = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         flush_i,
    input  logic [L-1:0] valid_i,
    input  logic [L-1:0] ready_i,
    input  logic [L-1:0] alloc_i,
    input  logic [L-1:0] free_i,
    output logic [L-1:0] sel_oh_c_o
);

    // older_q[i][j] = entry i was allocated before entry j
    logic [L-1:0][L-1:0] older_q, older_d;
    logic [L-1:0]        blocked;

    always_comb begin
        older_d = older_q;
        if (flush_i) begin
            older_d = '0;
        end else begin
            for (int unsigned k = 0; k < L; k++) begin
                if (alloc_i[k]) begin
                    older_d[k] = '0;
                    for (int unsigned j = 0; j < L; j++) begin
                        older_d[j][k] = valid_i[j] & ~free_i[j];
                    end
                end
            end
        end
    end

    // An entry wins when no ready peer is older than it
    always_comb begin
        blocked    = '0;
        sel_oh_c_o = '0;
        for (int unsigned i = 0; i < L; i++) begin
            for (int unsigned j = 0; j < L; j++) begin
                blocked[i] = blocked[i] | (ready_i[j] & older_q[j][i]);
            end
            sel_oh_c_o[i] = ready_i[i] & ~blocked[i];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end

endmodule

// File: rtl/eb_issue_scheduler.sv
// Out-of-order issue scheduler: holds dispatched ops, wakes sources on writeback,
// and issues the oldest ready op through a registered valid/ready stage.
module eb_issue_scheduler
    import nand_cpu_pkg::*;
#(
    parameter int unsigned L = EB_ENTRIES
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                disp_valid,
    output logic                disp_ready,
    input  eb_payload_t         disp_op,
    input  logic                disp_ra_rdy,
    input  logic                disp_rt_rdy,
    input  logic                wb_valid,
    input  logic [EB_TAG_W-1:0] wb_tag,
    output logic                iss_valid,
    input  logic                iss_ready,
    output eb_payload_t         iss_op,
    input  logic                flush,
    output logic [$clog2(L):0]  count
);

    localparam int unsigned CNT_W = $clog2(L) + 1;

    logic [L-1:0]     valid_q, valid_d;
    logic [L-1:0]     ra_rdy_q, ra_rdy_d;
    logic [L-1:0]     rt_rdy_q, rt_rdy_d;
    eb_payload_t      ent_q [L];
    eb_payload_t      ent_d [L];
    logic             iss_valid_q, iss_valid_d;
    eb_payload_t      iss_op_q, iss_op_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [L-1:0]     ready_c, sel_oh, alloc_oh, free_oh;
    logic             disp_fire, load, found;
    eb_payload_t      sel_op;

    assign disp_ready = (count_q != CNT_W'(L));
    assign disp_fire  = disp_valid & disp_ready & ~flush;
    assign load       = (|sel_oh) & (~iss_valid_q | iss_ready);
    assign free_oh    = load ? sel_oh : '0;

    assign iss_valid  = iss_valid_q;
    assign iss_op     = iss_op_q;
    assign count      = count_q;

    // Readiness, free-slot pick and selected payload, all from registered state
    always_comb begin
        ready_c  = '0;
        alloc_oh = '0;
        found    = 1'b0;
        sel_op   = '0;
        for (int unsigned i = 0; i < L; i++) begin
            ready_c[i] = valid_q[i] & (~ent_q[i].use_ra | ra_rdy_q[i])
                                    & (~ent_q[i].use_rt | rt_rdy_q[i]);
            if (!valid_q[i] && !found) begin
                alloc_oh[i] = disp_fire;
                found       = 1'b1;
            end
            if (sel_oh[i]) begin
                sel_op = ent_q[i];
            end
        end
    end

    eb_age_select #(.L(L)) u_age (
        .clk        (clk),
        .n_rst      (n_rst),
        .flush_i    (flush),
        .valid_i    (valid_q),
        .ready_i    (ready_c),
        .alloc_i    (alloc_oh),
        .free_i     (free_oh),
        .sel_oh_c_o (sel_oh)
    );

    always_comb begin
        valid_d     = valid_q & ~free_oh;
        ra_rdy_d    = ra_rdy_q;
        rt_rdy_d    = rt_rdy_q;
        ent_d       = ent_q;
        iss_valid_d = iss_valid_q;
        iss_op_d    = iss_op_q;
        count_d     = count_q + CNT_W'(disp_fire) - CNT_W'(load);

        for (int unsigned i = 0; i < L; i++) begin
            if (wb_valid && valid_q[i]) begin
                if (ent_q[i].ra_tag == wb_tag) ra_rdy_d[i] = 1'b1;
                if (ent_q[i].rt_tag == wb_tag) rt_rdy_d[i] = 1'b1;
            end
            // Writeback in the dispatch cycle is folded into the stored ready bits
            if (alloc_oh[i]) begin
                valid_d[i]  = 1'b1;
                ent_d[i]    = disp_op;
                ra_rdy_d[i] = ~disp_op.use_ra | disp_ra_rdy
                            | (wb_valid && (wb_tag == disp_op.ra_tag));
                rt_rdy_d[i] = ~disp_op.use_rt | disp_rt_rdy
                            | (wb_valid && (wb_tag == disp_op.rt_tag));
            end
        end

        if (load) begin
            iss_valid_d = 1'b1;
            iss_op_d    = sel_op;
        end else if (iss_ready) begin
            iss_valid_d = 1'b0;
        end

        if (flush) begin
            valid_d     = '0;
            ra_rdy_d    = '0;
            rt_rdy_d    = '0;
            iss_valid_d = 1'b0;
            iss_op_d    = '0;
            count_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q     <= '0;
            ra_rdy_q    <= '0;
            rt_rdy_q    <= '0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            count_q     <= '0;
            for (int unsigned i = 0; i < L; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            ra_rdy_q    <= ra_rdy_d;
            rt_rdy_q    <= rt_rdy_d;
            iss_valid_q <= iss_valid_d;
            iss_op_q    <= iss_op_d;
            count_q     <= count_d;
            ent_q       <= ent_d;
        end
    end

endmodule

// File: tb/tb_eb_issue_scheduler.sv
// Self-checking bench for eb_issue_scheduler: directed vector table, corner sequences
// and randomized traffic against a queue-based scheduler model.
module tb_eb_issue_scheduler;
    import nand_cpu_pkg::*;

    localparam int unsigned L     = EB_ENTRIES;
    localparam int unsigned CNT_W = $clog2(L) + 1;

    logic                clk;
    logic                n_rst;
    logic                disp_valid;
    logic                disp_ready;
    eb_payload_t         disp_op;
    logic                disp_ra_rdy;
    logic                disp_rt_rdy;
    logic                wb_valid;
    logic [EB_TAG_W-1:0] wb_tag;
    logic                iss_valid;
    logic                iss_ready;
    eb_payload_t         iss_op;
    logic                flush;
    logic [CNT_W-1:0]    count;

    int checks = 0;
    int errors = 0;

    eb_issue_scheduler #(.L(L)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_op     (disp_op),
        .disp_ra_rdy (disp_ra_rdy),
        .disp_rt_rdy (disp_rt_rdy),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_op      (iss_op),
        .flush       (flush),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_valid  = 1'b0;
        disp_op     = '0;
        disp_ra_rdy = 1'b0;
        disp_rt_rdy = 1'b0;
        wb_valid    = 1'b0;
        wb_tag      = '0;
        iss_ready   = 1'b0;
        flush       = 1'b0;
    endtask

    function automatic eb_payload_t mk(input logic [3:0] rob, input logic ura, input logic [3:0] rat,
                                       input logic urt, input logic [3:0] rtt);
        eb_payload_t p;
        p         = '0;
        p.alu_op  = ALU_ADD;
        p.immdt   = 6'(rob) + 6'd1;
        p.use_ra  = ura;
        p.ra_tag  = rat;
        p.use_rt  = urt;
        p.rt_tag  = rtt;
        p.rv_addr = 16'h1000 + 16'(rob);
        p.rob_tag = rob;
        return p;
    endfunction

    function automatic eb_payload_t rand_op();
        eb_payload_t p;
        p.alu_op  = AluOp'($urandom_range(0, 7));
        p.immdt   = 6'($urandom);
        p.use_ra  = 1'($urandom);
        p.ra_tag  = 4'($urandom_range(0, 3));
        p.use_rt  = 1'($urandom);
        p.rt_tag  = 4'($urandom_range(0, 3));
        p.use_rw  = 1'($urandom);
        p.rw_tag  = 4'($urandom);
        p.rv_addr = 16'($urandom);
        p.rs_addr = 16'($urandom);
        p.rob_tag = 4'($urandom);
        return p;
    endfunction

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        tick();
    endtask

    // Directed vector: one cycle of inputs and the state expected right after its edge
    typedef struct {
        logic       dv;
        logic [3:0] rob;
        logic       ura;
        logic [3:0] rat;
        logic       urt;
        logic [3:0] rtt;
        logic       wbv;
        logic [3:0] wbt;
        logic       ir;
        logic       e_iv;
        logic [3:0] e_rob;
        int         e_cnt;
    } vec_t;

    function automatic vec_t v(input logic dv, input logic [3:0] rob, input logic ura, input logic [3:0] rat,
                               input logic urt, input logic [3:0] rtt, input logic wbv, input logic [3:0] wbt,
                               input logic ir, input logic e_iv, input logic [3:0] e_rob, input int e_cnt);
        vec_t r;
        r.dv = dv; r.rob = rob; r.ura = ura; r.rat = rat; r.urt = urt; r.rtt = rtt;
        r.wbv = wbv; r.wbt = wbt; r.ir = ir; r.e_iv = e_iv; r.e_rob = e_rob; r.e_cnt = e_cnt;
        return r;
    endfunction

    // Reference model: entries in allocation order, oldest first
    typedef struct {
        eb_payload_t op;
        bit          ra;
        bit          rt;
    } ment_t;

    ment_t       mq[$];
    bit          m_iv;
    eb_payload_t m_op;

    task automatic model_step();
        int sel;
        bit ld;
        bit fire;
        ment_t n;
        sel = -1;
        for (int k = 0; k < mq.size(); k++) begin
            if (sel < 0 && (!mq[k].op.use_ra || mq[k].ra) && (!mq[k].op.use_rt || mq[k].rt)) sel = k;
        end
        ld   = (sel >= 0) && (!m_iv || iss_ready);
        fire = disp_valid && (mq.size() != L) && !flush;
        if (flush) begin
            mq.delete();
            m_iv = 1'b0;
        end else begin
            if (ld) begin
                m_iv = 1'b1;
                m_op = mq[sel].op;
                mq.delete(sel);
            end else if (iss_ready) begin
                m_iv = 1'b0;
            end
            for (int k = 0; k < mq.size(); k++) begin
                if (wb_valid && mq[k].op.ra_tag == wb_tag) mq[k].ra = 1'b1;
                if (wb_valid && mq[k].op.rt_tag == wb_tag) mq[k].rt = 1'b1;
            end
            if (fire) begin
                n.op = disp_op;
                n.ra = !disp_op.use_ra || disp_ra_rdy || (wb_valid && wb_tag == disp_op.ra_tag);
                n.rt = !disp_op.use_rt || disp_rt_rdy || (wb_valid && wb_tag == disp_op.rt_tag);
                mq.push_back(n);
            end
        end
    endtask

    vec_t vt[22];

    initial begin
        int acc;
        bool_blk: begin end
        vt[0]  = v(1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1);
        vt[1]  = v(1, 1, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1);
        vt[2]  = v(1, 2, 0, 0, 0, 0, 0, 0, 1,  1, 1, 1);
        vt[3]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 2, 0);
        vt[4]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0);
        vt[5]  = v(1, 3, 0, 0, 1, 3, 1, 3, 1,  0, 0, 1);
        vt[6]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 3, 0);
        vt[7]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0);
        vt[8]  = v(1, 4, 1, 5, 0, 0, 0, 0, 1,  0, 0, 1);
        vt[9]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1);
        vt[10] = v(0, 0, 0, 0, 0, 0, 1, 6, 1,  0, 0, 1);
        vt[11] = v(0, 0, 0, 0, 0, 0, 1, 5, 1,  0, 0, 1);
        vt[12] = v(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 4, 0);
        vt[13] = v(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0);
        vt[14] = v(1, 5, 1, 5, 0, 0, 0, 0, 0,  0, 0, 1);
        vt[15] = v(1, 6, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2);
        vt[16] = v(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 6, 1);
        vt[17] = v(0, 0, 0, 0, 0, 0, 1, 5, 0,  1, 6, 1);
        vt[18] = v(1, 7, 0, 0, 0, 0, 0, 0, 0,  1, 6, 2);
        vt[19] = v(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 5, 1);
        vt[20] = v(0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 7, 0);
        vt[21] = v(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0);

        idle_inputs();
        n_rst = 1'b0;
        #3;
        chk("reset_iss_valid", 64'(iss_valid), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_disp_ready", 64'(disp_ready), 64'd1);
        chk("reset_iss_op", 64'(iss_op), 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        // Directed table: ordering, bypass, wakeup and age
        for (int i = 0; i < 22; i++) begin
            disp_valid  = vt[i].dv;
            disp_op     = mk(vt[i].rob, vt[i].ura, vt[i].rat, vt[i].urt, vt[i].rtt);
            disp_ra_rdy = 1'b0;
            disp_rt_rdy = 1'b0;
            wb_valid    = vt[i].wbv;
            wb_tag      = vt[i].wbt;
            iss_ready   = vt[i].ir;
            tick();
            chk($sformatf("vec%0d_iss_valid", i), 64'(iss_valid), 64'(vt[i].e_iv));
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].e_cnt));
            chk($sformatf("vec%0d_disp_ready", i), 64'(disp_ready), 64'd1);
            if (vt[i].e_iv) chk($sformatf("vec%0d_rob", i), 64'(iss_op.rob_tag), 64'(vt[i].e_rob));
        end
        idle_inputs();
        tick();

        // Asynchronous reset in the middle of activity
        for (int i = 0; i < 4; i++) begin
            disp_valid = 1'b1;
            disp_op    = mk(4'(i), 0, 0, 0, 0);
            tick();
        end
        disp_valid = 1'b0;
        chk("pre_reset_count", 64'(count), 64'd3);
        chk("pre_reset_iss_valid", 64'(iss_valid), 64'd1);
        #3;
        n_rst = 1'b0;
        #1;
        chk("async_reset_iss_valid", 64'(iss_valid), 64'd0);
        chk("async_reset_count", 64'(count), 64'd0);
        chk("async_reset_disp_ready", 64'(disp_ready), 64'd1);
        #2;
        n_rst = 1'b1;
        tick();
        chk("post_reset_iss_valid", 64'(iss_valid), 64'd0);

        // Fill to capacity under backpressure
        acc = 0;
        for (int c = 0; c < L + 4; c++) begin
            logic took;
            disp_valid = 1'b1;
            disp_op    = mk(4'(acc), 0, 0, 0, 0);
            iss_ready  = 1'b0;
            took       = disp_ready;
            tick();
            if (took) acc++;
            if (c >= 2) chk("full_rob_stable", 64'(iss_op.rob_tag), 64'd0);
        end
        chk("full_accepted", 64'(acc), 64'(L + 1));
        chk("full_count", 64'(count), 64'(L));
        chk("full_disp_ready", 64'(disp_ready), 64'd0);
        chk("full_iss_valid", 64'(iss_valid), 64'd1);
        disp_valid = 1'b0;
        iss_ready  = 1'b1;
        tick();
        chk("release_count", 64'(count), 64'(L - 1));
        chk("release_disp_ready", 64'(disp_ready), 64'd1);
        chk("release_rob", 64'(iss_op.rob_tag), 64'd1);
        for (int r = 2; r <= L; r++) begin
            tick();
            chk($sformatf("drain_rob%0d", r), 64'(iss_op.rob_tag), 64'(r));
            chk($sformatf("drain_count%0d", r), 64'(count), 64'(L - r));
        end
        tick();
        chk("drain_iss_valid", 64'(iss_valid), 64'd0);

        // Flush with five entries held and a dispatch in the flush cycle
        iss_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            disp_valid = 1'b1;
            disp_op    = mk(4'(i), 0, 0, 0, 0);
            tick();
        end
        chk("preflush_count", 64'(count), 64'd5);
        chk("preflush_iss_valid", 64'(iss_valid), 64'd1);
        disp_op = mk(4'd15, 0, 0, 0, 0);
        flush   = 1'b1;
        tick();
        flush      = 1'b0;
        disp_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_iss_valid", 64'(iss_valid), 64'd0);
        chk("flush_disp_ready", 64'(disp_ready), 64'd1);
        iss_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("flush_nothing_issues", 64'(iss_valid), 64'd0);
        end

        // Randomized traffic against the model
        do_reset();
        mq.delete();
        m_iv = 1'b0;
        m_op = '0;
        for (int c = 0; c < 3000; c++) begin
            int bp;
            bp          = ((c / 250) % 2 == 0) ? 3 : 1;
            disp_valid  = ($urandom % 4) != 0;
            disp_op     = rand_op();
            disp_ra_rdy = ($urandom % 4) == 0;
            disp_rt_rdy = ($urandom % 4) == 0;
            wb_valid    = ($urandom % 3) == 0;
            wb_tag      = 4'($urandom_range(0, 3));
            iss_ready   = ($urandom % 4) < bp;
            flush       = ($urandom % 150) == 0;
            chk("rnd_disp_ready", 64'(disp_ready), 64'(mq.size() != L));
            model_step();
            tick();
            chk("rnd_iss_valid", 64'(iss_valid), 64'(m_iv));
            chk("rnd_count", 64'(count), 64'(mq.size()));
            if (m_iv) chk("rnd_iss_op", 64'(iss_op), 64'(m_op));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
